// File: rtl/sync_conditioner.sv
// sync_conditioner: synchronise and deglitch TIA hsync/vsync, then measure the
// hsync line period and report lock once the line rate is stable.
module sync_conditioner #(
  parameter int FILT_LEN     = 4,
  parameter int PERIOD_WIDTH = 12,
  parameter int PERIOD_TOL   = 4,
  parameter int LOCK_LINES   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    hsync_raw,
  input  logic                    vsync_raw,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    hfall,
  output logic                    locked,
  output logic [PERIOD_WIDTH-1:0] line_period
);
  localparam int MW = $clog2(LOCK_LINES + 1);
  localparam logic [1:0] S_SEARCH  = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_TRACK   = 2'd2;
  localparam logic [1:0] S_LOCKED  = 2'd3;
  localparam logic [PERIOD_WIDTH-1:0] PMAX = '1;

  logic [1:0]              r_hs_sync, r_vs_sync;
  logic [3:0]              r_hcnt, r_vcnt;
  logic                    r_hsync, r_vsync, r_hfall, r_locked;
  logic [PERIOD_WIDTH-1:0] r_pc, r_ref;
  logic [MW-1:0]           r_mcnt;
  logic [1:0]              r_state;
  logic                    w_htog, w_vtog, w_timeout, w_match;
  logic [PERIOD_WIDTH-1:0] w_diff, w_ref_nx;
  logic [MW-1:0]           w_mcnt_nx;
  logic [1:0]              w_state_nx;

  // bit 1 of each synchroniser is the settled sample seen by the filter
  assign w_htog    = (r_hs_sync[1] != r_hsync) && (r_hcnt == 4'(FILT_LEN - 1));
  assign w_vtog    = (r_vs_sync[1] != r_vsync) && (r_vcnt == 4'(FILT_LEN - 1));
  assign w_timeout = (r_pc == PMAX) && !r_hfall;
  assign w_diff    = r_pc >= r_ref ? r_pc - r_ref : r_ref - r_pc;
  assign w_match   = w_diff <= PERIOD_WIDTH'(PERIOD_TOL);

  always_comb begin
    w_state_nx = r_state;
    w_ref_nx   = r_ref;
    w_mcnt_nx  = r_mcnt;
    if (r_hfall) begin
      case (r_state)
        S_SEARCH: w_state_nx = S_MEASURE;
        S_MEASURE: begin
          w_state_nx = S_TRACK;
          w_ref_nx   = r_pc;
          w_mcnt_nx  = MW'(1);
        end
        S_TRACK: begin
          w_ref_nx   = r_pc;
          w_mcnt_nx  = w_match ? r_mcnt + MW'(1) : MW'(1);
          w_state_nx = (w_match && r_mcnt == MW'(LOCK_LINES - 1)) ? S_LOCKED : S_TRACK;
        end
        default: if (!w_match) begin
          w_state_nx = S_TRACK;
          w_ref_nx   = r_pc;
          w_mcnt_nx  = MW'(1);
        end
      endcase
    end else if (w_timeout) begin
      w_state_nx = S_SEARCH;
      w_mcnt_nx  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_sync <= 2'b11;
      r_vs_sync <= 2'b11;
      r_hcnt    <= '0;
      r_vcnt    <= '0;
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
      r_hfall   <= 1'b0;
      r_pc      <= '0;
      r_ref     <= '0;
      r_mcnt    <= '0;
      r_state   <= S_SEARCH;
      r_locked  <= 1'b0;
    end else begin
      r_hs_sync <= {r_hs_sync[0], hsync_raw};
      r_vs_sync <= {r_vs_sync[0], vsync_raw};
      r_hcnt    <= (r_hs_sync[1] == r_hsync || w_htog) ? 4'd0 : r_hcnt + 4'd1;
      r_vcnt    <= (r_vs_sync[1] == r_vsync || w_vtog) ? 4'd0 : r_vcnt + 4'd1;
      r_hsync   <= r_hsync ^ w_htog;
      r_vsync   <= r_vsync ^ w_vtog;
      r_hfall   <= r_hsync & w_htog;
      r_pc      <= r_hfall ? PERIOD_WIDTH'(1) : (r_pc == PMAX ? PMAX : r_pc + PERIOD_WIDTH'(1));
      r_ref     <= w_ref_nx;
      r_mcnt    <= w_mcnt_nx;
      r_state   <= w_state_nx;
      r_locked  <= (w_state_nx == S_LOCKED);
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign hfall       = r_hfall;
  assign locked      = r_locked;
  assign line_period = r_ref;
endmodule

// File: tb/tb_sync_conditioner.sv
// tb_sync_conditioner: randomized scenarios checked against a sliding-window
// filter and line-period lock model, plus directed timing checks.
module tb_sync_conditioner;
  localparam int FL = 4, TOL = 4, LOCK = 8, PMAX = 4095;
  localparam int S_SEARCH = 0, S_MEASURE = 1, S_TRACK = 2, S_LOCKED = 3;

  logic clk = 0, rst_n = 0, hsync_raw = 1, vsync_raw = 1;
  logic hsync, vsync, hfall, locked;
  logic [11:0] line_period;

  int n_checks = 0, n_fail = 0, cyc = 0, mm_cnt = 0, hlow_cnt = 0;
  int lk_rise = -1, lk_fall = -1, hs_fall_cyc = -1, vs_hold = 0;
  bit vs_en = 0, prev_lk = 0, prev_hs = 1;
  int hf_times[$];

  logic [15:0] mh_h = '1, mh_v = '1;
  bit m_hs = 1, m_vs = 1, m_hf = 0, m_lk = 0;
  int m_pc = 0, m_ref = 0, m_mc = 0, m_st = S_SEARCH;

  sync_conditioner dut (
    .clk(clk), .rst_n(rst_n), .hsync_raw(hsync_raw), .vsync_raw(vsync_raw),
    .hsync(hsync), .vsync(vsync), .hfall(hfall), .locked(locked), .line_period(line_period)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // output flips once the last FL settled samples (2 clocks old and older) all disagree with it
  function automatic bit settled(logic [15:0] h, bit o);
    for (int j = 2; j <= FL + 1; j++) if (h[j] == o) return 0;
    return 1;
  endfunction

  task automatic model_reset;
    mh_h = '1; mh_v = '1; m_hs = 1; m_vs = 1; m_hf = 0; m_lk = 0;
    m_pc = 0; m_ref = 0; m_mc = 0; m_st = S_SEARCH;
  endtask

  task automatic model_step;
    int d;
    bit fell;
    if (m_hf) begin
      d = m_pc > m_ref ? m_pc - m_ref : m_ref - m_pc;
      if (m_st == S_SEARCH) m_st = S_MEASURE;
      else if (m_st == S_MEASURE) begin m_ref = m_pc; m_mc = 1; m_st = S_TRACK; end
      else if (m_st == S_TRACK) begin
        m_ref = m_pc;
        if (d <= TOL) begin m_mc++; if (m_mc == LOCK) m_st = S_LOCKED; end
        else m_mc = 1;
      end else if (d > TOL) begin m_ref = m_pc; m_mc = 1; m_st = S_TRACK; end
    end else if (m_pc == PMAX) begin
      m_mc = 0; m_st = S_SEARCH;
    end
    m_lk = (m_st == S_LOCKED);
    m_pc = m_hf ? 1 : (m_pc < PMAX ? m_pc + 1 : PMAX);
    mh_h = {mh_h[14:0], hsync_raw};
    mh_v = {mh_v[14:0], vsync_raw};
    fell = m_hs && settled(mh_h, m_hs);
    if (settled(mh_h, m_hs)) m_hs = !m_hs;
    if (settled(mh_v, m_vs)) m_vs = !m_vs;
    m_hf = fell;
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) model_reset; else model_step;

  task automatic monitor_step;
    if (rst_n) begin
      if (hfall === 1'b1) hf_times.push_back(cyc);
      if (locked === 1'b1 && !prev_lk) lk_rise = cyc;
      if (locked === 1'b0 && prev_lk) lk_fall = cyc;
      if (hsync === 1'b0 && prev_hs) hs_fall_cyc = cyc;
      if (hsync === 1'b0) hlow_cnt++;
      if ({hsync, vsync, hfall, locked, line_period} !== {m_hs, m_vs, m_hf, m_lk, 12'(m_ref)}) begin
        mm_cnt++;
        if (mm_cnt <= 3) $display("model divergence at cycle %0d: dut=%b%b%b%b %0d model=%b%b%b%b %0d",
          cyc, hsync, vsync, hfall, locked, line_period, m_hs, m_vs, m_hf, m_lk, m_ref);
      end
    end
    prev_lk = (locked === 1'b1);
    prev_hs = (hsync !== 1'b0);
  endtask

  always @(negedge clk) monitor_step;

  initial forever begin
    @(negedge clk);
    if (vs_en && vs_hold == 0) begin vsync_raw = ~vsync_raw; vs_hold = $urandom_range(1, 30); end
    else if (vs_hold > 0) vs_hold--;
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    tick(1); rst_n = 0; tick(3); rst_n = 1;
  endtask

  task automatic send_line(int period, int low);
    hsync_raw = 0; tick(low); hsync_raw = 1; tick(period - low);
  endtask

  task automatic test_reset;
    int mm0, hf0;
    hsync_raw = 1; do_reset;
    n_checks++; if (hsync !== 1'b1) begin n_fail++; $display("FAIL reset_hsync: got %b expected 1", hsync); end
    n_checks++; if (vsync !== 1'b1) begin n_fail++; $display("FAIL reset_vsync: got %b expected 1", vsync); end
    n_checks++; if (hfall !== 1'b0) begin n_fail++; $display("FAIL reset_hfall: got %b expected 0", hfall); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
    n_checks++; if (line_period !== 12'd0) begin n_fail++; $display("FAIL reset_period: got %0d expected 0", line_period); end
    mm0 = mm_cnt; hf0 = hf_times.size();
    tick(100);
    n_checks++; if (hf_times.size() - hf0 !== 0) begin n_fail++; $display("FAIL idle_hfall: got %0d pulses expected 0", hf_times.size() - hf0); end
    n_checks++; if ({hsync, vsync, locked} !== 3'b110) begin n_fail++; $display("FAIL idle_outputs: got %b expected 110", {hsync, vsync, locked}); end
    n_checks++; if (line_period !== 12'd0) begin n_fail++; $display("FAIL idle_period: got %0d expected 0", line_period); end
    n_checks++; if (mm_cnt - mm0 !== 0) begin n_fail++; $display("FAIL idle_model: got %0d divergent cycles expected 0", mm_cnt - mm0); end
  endtask

  task automatic test_glitch;
    int hf0, hl0, t0, mm0;
    hf0 = hf_times.size(); hl0 = hlow_cnt; mm0 = mm_cnt;
    hsync_raw = 0; tick(3); hsync_raw = 1; tick(20);
    for (int i = 0; i < 6; i++) begin
      hsync_raw = 0; tick($urandom_range(1, FL - 1)); hsync_raw = 1; tick($urandom_range(FL, 12));
    end
    n_checks++; if (hlow_cnt - hl0 !== 0) begin n_fail++; $display("FAIL glitch_hsync: got %0d low cycles expected 0", hlow_cnt - hl0); end
    n_checks++; if (hf_times.size() - hf0 !== 0) begin n_fail++; $display("FAIL glitch_hfall: got %0d pulses expected 0", hf_times.size() - hf0); end
    t0 = cyc; hsync_raw = 0; tick(4); hsync_raw = 1; tick(20);
    n_checks++; if (hs_fall_cyc - t0 !== 6) begin n_fail++; $display("FAIL pulse_latency: got %0d expected 6", hs_fall_cyc - t0); end
    n_checks++; if (hf_times.size() - hf0 !== 1) begin n_fail++; $display("FAIL pulse_hfall: got %0d pulses expected 1", hf_times.size() - hf0); end
    n_checks++; if (hlow_cnt - hl0 !== 4) begin n_fail++; $display("FAIL pulse_width: got %0d low cycles expected 4", hlow_cnt - hl0); end
    n_checks++; if (mm_cnt - mm0 !== 0) begin n_fail++; $display("FAIL glitch_model: got %0d divergent cycles expected 0", mm_cnt - mm0); end
    vs_en = 1;
  endtask

  task automatic test_lock;
    int b, mm0;
    hsync_raw = 1; do_reset; tick(50);
    b = hf_times.size(); mm0 = mm_cnt;
    send_line(764, 64); send_line(764, 64);
    n_checks++; if (line_period !== 12'd764) begin n_fail++; $display("FAIL lock_period_2nd: got %0d expected 764", line_period); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %b expected 0", locked); end
    repeat (8) send_line(764, 64);
    n_checks++; if (hf_times.size() - b !== 10) begin n_fail++; $display("FAIL lock_hfall_count: got %0d expected 10", hf_times.size() - b); end
    if (hf_times.size() - b >= 10) begin
      for (int i = 1; i < 10; i++) begin
        n_checks++; if (hf_times[b+i] - hf_times[b+i-1] !== 764) begin n_fail++; $display("FAIL lock_spacing_%0d: got %0d expected 764", i, hf_times[b+i] - hf_times[b+i-1]); end
      end
      n_checks++; if (lk_rise !== hf_times[b+8] + 1) begin n_fail++; $display("FAIL lock_rise: got cycle %0d expected %0d", lk_rise, hf_times[b+8] + 1); end
    end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_state: got %b expected 1", locked); end
    n_checks++; if (mm_cnt - mm0 !== 0) begin n_fail++; $display("FAIL lock_model: got %0d divergent cycles expected 0", mm_cnt - mm0); end
  endtask

  task automatic test_tolerance;
    send_line(767, 64); send_line(780, 64);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL tol_locked: got %b expected 1", locked); end
    n_checks++; if (line_period !== 12'd764) begin n_fail++; $display("FAIL tol_period: got %0d expected 764", line_period); end
  endtask

  task automatic test_relock;
    int b, mm0;
    b = hf_times.size(); mm0 = mm_cnt;
    repeat (8) send_line(780, 64);
    if (hf_times.size() - b >= 8) begin
      n_checks++; if (lk_fall !== hf_times[b] + 1) begin n_fail++; $display("FAIL unlock_cycle: got %0d expected %0d", lk_fall, hf_times[b] + 1); end
      n_checks++; if (lk_rise !== hf_times[b+7] + 1) begin n_fail++; $display("FAIL relock_cycle: got %0d expected %0d", lk_rise, hf_times[b+7] + 1); end
    end else begin
      n_checks++; n_fail++; $display("FAIL relock_hfall_count: got %0d expected 8", hf_times.size() - b);
    end
    n_checks++; if (line_period !== 12'd780) begin n_fail++; $display("FAIL relock_period: got %0d expected 780", line_period); end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL relock_state: got %b expected 1", locked); end
    n_checks++; if (mm_cnt - mm0 !== 0) begin n_fail++; $display("FAIL relock_model: got %0d divergent cycles expected 0", mm_cnt - mm0); end
  endtask

  task automatic test_timeout;
    int b, mm0;
    b = hf_times.size(); mm0 = mm_cnt;
    tick(4200);
    n_checks++; if (lk_fall !== hf_times[b-1] + 4096) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected %0d", lk_fall, hf_times[b-1] + 4096); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL timeout_locked: got %b expected 0", locked); end
    b = hf_times.size();
    repeat (9) send_line(764, 64);
    if (hf_times.size() - b >= 9) begin
      n_checks++; if (lk_rise !== hf_times[b+8] + 1) begin n_fail++; $display("FAIL resume_lock: got %0d expected %0d", lk_rise, hf_times[b+8] + 1); end
    end else begin
      n_checks++; n_fail++; $display("FAIL resume_hfall_count: got %0d expected 9", hf_times.size() - b);
    end
    n_checks++; if (line_period !== 12'd764) begin n_fail++; $display("FAIL resume_period: got %0d expected 764", line_period); end
    n_checks++; if (mm_cnt - mm0 !== 0) begin n_fail++; $display("FAIL timeout_model: got %0d divergent cycles expected 0", mm_cnt - mm0); end
  endtask

  task automatic test_reset_mid;
    int b;
    tick(100);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL prereset_locked: got %b expected 1", locked); end
    #1 rst_n = 0;
    #1;
    n_checks++; if ({hsync, vsync, hfall, locked} !== 4'b1100) begin n_fail++; $display("FAIL async_reset_flags: got %b expected 1100", {hsync, vsync, hfall, locked}); end
    n_checks++; if (line_period !== 12'd0) begin n_fail++; $display("FAIL async_reset_period: got %0d expected 0", line_period); end
    tick(2); rst_n = 1; tick(50);
    b = hf_times.size();
    repeat (9) send_line(764, 64);
    if (hf_times.size() - b >= 9) begin
      n_checks++; if (lk_rise !== hf_times[b+8] + 1) begin n_fail++; $display("FAIL postreset_lock: got %0d expected %0d", lk_rise, hf_times[b+8] + 1); end
    end else begin
      n_checks++; n_fail++; $display("FAIL postreset_hfall_count: got %0d expected 9", hf_times.size() - b);
    end
  endtask

  task automatic test_random;
    int b, mm0, per, low, off, glen;
    b = hf_times.size(); mm0 = mm_cnt;
    for (int i = 0; i < 20; i++) begin
      per  = 762 + int'($urandom_range(0, 4));
      low  = $urandom_range(20, 100);
      off  = $urandom_range(low + 10, per - 20);
      glen = $urandom_range(1, FL - 1);
      hsync_raw = 0; tick(low); hsync_raw = 1; tick(off - low);
      hsync_raw = 0; tick(glen); hsync_raw = 1; tick(per - off - glen);
    end
    n_checks++; if (hf_times.size() - b !== 20) begin n_fail++; $display("FAIL random_hfall_count: got %0d expected 20", hf_times.size() - b); end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL random_locked: got %b expected 1", locked); end
    n_checks++; if (line_period !== 12'd764) begin n_fail++; $display("FAIL random_period: got %0d expected 764", line_period); end
    n_checks++; if (mm_cnt - mm0 !== 0) begin n_fail++; $display("FAIL random_model: got %0d divergent cycles expected 0", mm_cnt - mm0); end
  endtask

  initial begin
    test_reset;
    test_glitch;
    test_lock;
    test_tolerance;
    test_relock;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
